// File: rtl/udp_echo_responder_pkg.sv
// Shared types and defaults for the UDP echo responder.
// Holds the FSM encoding and the default payload limits.
package udp_echo_responder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        DROP,
        WAIT_RDY,
        SEND
    } state_t;

    // 1500-byte MTU minus 20-byte IP and 8-byte UDP headers
    localparam int unsigned MAX_LEN_DEF   = 1472;
    localparam int unsigned BUF_DEPTH_DEF = 2048;

endpackage

// File: rtl/udp_echo_responder_if.sv
// Receive/send stream bundle between the UDP stack and the echo responder.
// master = stack side, slave = responder side.
interface udp_echo_responder_if;

    logic        i_echo_en;
    logic [7:0]  i_recv_udp_data;
    logic [15:0] i_recv_udp_len;
    logic        i_recv_udp_last;
    logic        i_recv_udp_valid;
    logic        i_send_ready;
    logic [7:0]  o_send_udp_data;
    logic [15:0] o_send_udp_len;
    logic        o_send_udp_last;
    logic        o_send_udp_valid;
    logic [15:0] o_echo_cnt;
    logic [15:0] o_drop_cnt;

    modport master (
        output i_echo_en, i_recv_udp_data, i_recv_udp_len,
        output i_recv_udp_last, i_recv_udp_valid, i_send_ready,
        input  o_send_udp_data, o_send_udp_len, o_send_udp_last,
        input  o_send_udp_valid, o_echo_cnt, o_drop_cnt
    );

    modport slave (
        input  i_echo_en, i_recv_udp_data, i_recv_udp_len,
        input  i_recv_udp_last, i_recv_udp_valid, i_send_ready,
        output o_send_udp_data, o_send_udp_len, o_send_udp_last,
        output o_send_udp_valid, o_echo_cnt, o_drop_cnt
    );

endinterface

// File: rtl/udp_echo_buf.sv
// Simple dual-port byte RAM: synchronous write, registered read.
// No reset on storage or read port so it maps onto block RAM.
module udp_echo_buf #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/udp_echo_responder.sv
// Buffers one received UDP payload and returns it unchanged on the send
// stream once the stack signals ready.
module udp_echo_responder
    import udp_echo_responder_pkg::*;
#(
    parameter int unsigned P_BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned P_MAX_LEN   = MAX_LEN_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    udp_echo_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(P_BUF_DEPTH);

    state_t        state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic [15:0]   len_q;
    logic [15:0]   echo_cnt;
    logic [15:0]   drop_cnt;
    logic          skip_q;
    logic          rd_pend;
    logic          rd_last;
    logic [7:0]    send_data;
    logic [15:0]   send_len;
    logic          send_last;
    logic          send_valid;

    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [7:0]    buf_rdata;

    logic          vld;
    logic          lst;
    logic          skip;
    logic          accept;
    logic          wr_room;
    logic [15:0]   wr_next16;
    logic [15:0]   rd_cnt16;

    assign vld       = bus.i_recv_udp_valid;
    assign lst       = bus.i_recv_udp_last;
    assign wr_next16 = 16'(wr_cnt) + 16'd1;
    assign rd_cnt16  = 16'(rd_cnt);
    assign wr_room   = 16'(wr_cnt) < len_q;
    // traffic seen while an echo is pending is discarded until its last byte
    assign skip      = skip_q || state == WAIT_RDY || state == SEND;
    assign accept    = bus.i_echo_en
                    && bus.i_recv_udp_len != 16'd0
                    && bus.i_recv_udp_len <= 16'(P_MAX_LEN);

    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = wr_cnt;
        unique case (1'b1)
            vld && !skip && state == IDLE && accept: begin
                buf_we    = 1'b1;
                buf_waddr = '0;
            end
            vld && !skip && state == RECV && wr_room: begin
                buf_we = 1'b1;
            end
            default: ;
        endcase
    end

    udp_echo_buf #(
        .DEPTH (P_BUF_DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (i_clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (bus.i_recv_udp_data),
        .raddr (rd_cnt),
        .rdata (buf_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            len_q      <= '0;
            echo_cnt   <= '0;
            drop_cnt   <= '0;
            skip_q     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_last    <= 1'b0;
            send_data  <= '0;
            send_len   <= '0;
            send_last  <= 1'b0;
            send_valid <= 1'b0;
        end else begin
            rd_pend    <= 1'b0;
            rd_last    <= 1'b0;
            send_valid <= rd_pend;
            send_data  <= rd_pend ? buf_rdata : 8'd0;
            send_len   <= rd_pend ? len_q : 16'd0;
            send_last  <= rd_pend && rd_last;

            if (skip && vld) begin
                if (lst) begin
                    drop_cnt <= drop_cnt + 16'd1;
                    skip_q   <= 1'b0;
                end else begin
                    skip_q   <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (vld && !skip) begin
                        if (accept) begin
                            len_q  <= bus.i_recv_udp_len;
                            wr_cnt <= AW'(1);
                        end
                        if (accept && !lst)
                            state <= RECV;
                        else if (accept && bus.i_recv_udp_len == 16'd1)
                            state <= WAIT_RDY;
                        else if (!lst)
                            state <= DROP;
                        else
                            drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                RECV: begin
                    if (vld) begin
                        if (wr_room)
                            wr_cnt <= wr_cnt + AW'(1);
                        if (lst) begin
                            if (wr_next16 == len_q) begin
                                state <= WAIT_RDY;
                            end else begin
                                drop_cnt <= drop_cnt + 16'd1;
                                state    <= IDLE;
                            end
                        end else if (!wr_room) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (vld && lst) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end
                WAIT_RDY: begin
                    rd_cnt <= '0;
                    if (bus.i_send_ready)
                        state <= SEND;
                end
                SEND: begin
                    if (rd_cnt16 < len_q) begin
                        rd_pend <= 1'b1;
                        rd_last <= rd_cnt16 + 16'd1 == len_q;
                        rd_cnt  <= rd_cnt + AW'(1);
                    end
                    if (rd_pend && rd_last) begin
                        echo_cnt <= echo_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_send_udp_data  = send_data;
    assign bus.o_send_udp_len   = send_len;
    assign bus.o_send_udp_last  = send_last;
    assign bus.o_send_udp_valid = send_valid;
    assign bus.o_echo_cnt       = echo_cnt;
    assign bus.o_drop_cnt       = drop_cnt;

endmodule

// File: doc/udp_echo_responder.md
Name: udp_echo_responder

Overview:
- User-side application block at the far end of the UDP stack's data ports.
- Consumes received UDP payloads from the stack's receive stream, stores one datagram in an on-chip byte buffer, then returns it unchanged through the stack's send stream under the stack's ready handshake.
- Serves as loopback/ping responder for board bring-up and as a reference consumer/producer for the stack's user interface.

Parameters:
- P_BUF_DEPTH, 2048, payload buffer depth in bytes; power of two, must be at least P_MAX_LEN.
- P_MAX_LEN, 1472, largest payload length accepted; larger datagrams are dropped.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_echo_en  in  1  1 = accept and echo datagrams; 0 = discard all received datagrams.
- i_recv_udp_data  in  8  received payload byte.
- i_recv_udp_len  in  16  payload length; valid and constant while i_recv_udp_valid is high.
- i_recv_udp_last  in  1  final payload byte.
- i_recv_udp_valid  in  1  byte strobe; no backpressure possible.
- i_send_ready  in  1  stack can accept the next send frame.
- o_send_udp_data  out  8  echoed payload byte.
- o_send_udp_len  out  16  echoed payload length; constant for the whole frame.
- o_send_udp_last  out  1  final echoed byte.
- o_send_udp_valid  out  1  echoed byte strobe.
- o_echo_cnt  out  16  count of completed echoes; wraps.
- o_drop_cnt  out  16  count of dropped datagrams; wraps.

Behaviour:
- Reset (async assert, sync release): FSM to IDLE. All outputs, counters, write/read counts and the length register are 0.
- FSM states: IDLE, RECV, DROP, WAIT_RDY, SEND.
- IDLE, on i_recv_udp_valid:
  - Accept if i_echo_en=1 and 1 <= i_recv_udp_len <= P_MAX_LEN. Latch the length, write the byte at address 0, set write count to 1, go to RECV.
  - Otherwise go to DROP.
  - A valid byte with last in IDLE is a single-byte frame: accepted if len=1, then go directly to WAIT_RDY.
- RECV:
  - Each valid byte is written at the current write count, then the count increments.
  - On last: if the final count equals the latched length, go to WAIT_RDY; otherwise increment o_drop_cnt and go to IDLE.
  - If the count would exceed the latched length before last arrives, go to DROP.
- DROP: ignore bytes until a valid byte with last. Then increment o_drop_cnt and go to IDLE. A last that arrives in the entry cycle counts immediately.
- Receive traffic arriving in WAIT_RDY or SEND is discarded without buffering. Each such datagram increments o_drop_cnt once, on its last byte; the tracking flag is separate from the FSM.
- WAIT_RDY:
  - Buffer read address is preset to 0.
  - When i_send_ready=1 is sampled, go to SEND the next cycle.
  - Buffer read latency is 1 cycle, so the first byte appears with o_send_udp_valid=1 exactly 2 cycles after the ready-sampled edge.
- SEND:
  - o_send_udp_valid stays high for exactly len consecutive cycles with no gaps.
  - o_send_udp_len holds the latched length throughout the frame.
  - o_send_udp_last is high only on byte len.
  - i_send_ready is not re-checked mid-frame.
  - After last: increment o_echo_cnt and go to IDLE. This gives a minimum 1-cycle gap before the next frame can be accepted.
- i_echo_en falling mid-RECV or mid-SEND: the frame in progress completes; the enable affects only the next acceptance in IDLE.
- Arithmetic: write/read counters are log2(P_BUF_DEPTH) bits wide; the length comparison uses 16 bits; counters wrap 0xFFFF -> 0.
- Outputs are registered. Data, len and last are 0 whenever valid=0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/RECV/DROP/WAIT_RDY/SEND);
  - default P_MAX_LEN = 1472 (1500 - 20 IP - 8 UDP).
- One sub-module: udp_echo_buf, a simple dual-port byte RAM (P_BUF_DEPTH x 8, synchronous write, 1-cycle registered read) suited to BRAM inference.

Test Plan:
- 64-byte datagram (bytes 0x00..0x3F, len=64), i_send_ready=1 → after last, echo of 64 bytes with identical data, o_send_udp_len=64, last on byte 64, o_echo_cnt=1.
- Same 64-byte datagram with i_send_ready held 0 for 50 cycles then raised → o_send_udp_valid stays 0 until 2 cycles after ready is sampled, then contiguous 64-byte echo.
- len=1500 datagram → no echo, o_drop_cnt=1. len=0 → dropped. len=1472 → full echo.
- len=10 declared but last on byte 8, then a valid 16-byte datagram → first dropped (o_drop_cnt=1), second echoed correctly.
- Second datagram arrives during SEND of the first → first echo unaffected, second dropped, o_drop_cnt=1, o_echo_cnt=1.
- Reset (i_rst=0) mid-SEND at byte 20 → all outputs 0 immediately. After release, a new 32-byte datagram echoes correctly and o_echo_cnt counts from 0.
